imem_loader: RTL and testbench

- Writer side of the instruction-memory read path: receives a program image as a byte stream and writes it into a writable instruction memory.
- Holds the CPU (cpu_hold) while loading; releases it only after a valid image, so the core fetches from address 0 into a fully written program.
- Sits between a host byte source (valid/ready) and the instruction memory write port, alongside the program counter.

---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types, width defaults and checksum helper for the
//                instruction-memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Default widths: address matches the PC, one stream byte per instruction
    localparam int c_ADDR_W_DFLT = 8;
    localparam int c_DATA_W_DFLT = 8;

    // Width the checksum helper works at; callers truncate to DATA_W, which
    // yields the modulo-2^DATA_W sum. DATA_W must not exceed this.
    localparam int c_CSUM_W = 32;

    // Loader states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Running checksum step: plain addition, wrap handled by truncation
    function automatic logic [c_CSUM_W-1:0] csum_add(
        input logic [c_CSUM_W-1:0] acc,
        input logic [c_CSUM_W-1:0] b
    );
        return acc + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a framed program image (LEN, payload, CSUM) over a
//                valid/ready byte stream, writes the payload into the
//                instruction memory from address 0 and holds the CPU until a
//                frame with a good checksum has been fully written.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DFLT,
    parameter int DATA_W = c_DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Compare width wide enough for both the counter and the length byte
    localparam int c_CMP_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_sum;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic                w_in_ready;
    logic                w_hs;
    logic [DATA_W-1:0]   w_sum_nxt;
    logic                w_csum_ok;
    logic [c_CMP_W-1:0]  w_cnt_p1;
    logic                w_cnt_last;

    // The loader is receptive exactly while a frame is in progress
    assign w_in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_hs       = in_valid && w_in_ready;

    // Sum including the current byte; in CSUM this is the final frame check
    assign w_sum_nxt  = DATA_W'(csum_add(c_CSUM_W'(r_sum), c_CSUM_W'(in_data)));
    assign w_csum_ok  = (w_sum_nxt == '0);

    // The current payload byte is the last one when cnt == len-1
    assign w_cnt_p1   = c_CMP_W'(r_cnt) + c_CMP_W'(1);
    assign w_cnt_last = (w_cnt_p1 == c_CMP_W'(r_len));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: frame progress driven by handshakes, restart by start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_hs) begin
                    w_state_nxt = (in_data == '0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs && w_cnt_last) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_hs) begin
                    w_state_nxt = w_csum_ok ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded purely from the current state; the CPU runs only in DONE
    always_comb begin
        in_ready = w_in_ready;
        busy     = w_in_ready;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR: begin
                err      = 1'b1;
            end
            default: begin
                done     = 1'b0;
            end
        endcase
    end

    // Frame datapath: length capture, payload count/sum and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Write strobe lasts one cycle per accepted payload byte
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_sum <= '0;
                        r_cnt <= '0;
                    end
                end
                S_LEN: begin
                    if (w_hs) begin
                        r_len <= in_data;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt;
                        r_wr_data <= in_data;
                        r_cnt     <= r_cnt + ADDR_W'(1);
                        r_sum     <= w_sum_nxt;
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader: directed frames plus
//                randomized frames checked against a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp;
    int n_mis;
    int wr_total;

    logic [7:0] mem_obs [256];
    logic [7:0] mem_exp [256];

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed memory image and write count, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            wr_total = wr_total + 1;
            mem_obs[wr_addr] = wr_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte after some idle cycles; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax,
                             input bit pulse_start, output bit ok);
        int gaps;
        bit rdy;
        ok   = 1'b0;
        gaps = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = pulse_start && (g == 0);
            @(posedge clk);
            @(negedge clk);
            start    = 1'b0;
        end
        for (int t = 0; t < 100 && !ok; t++) begin
            in_valid = 1'b1;
            in_data  = b;
            rdy      = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!ok) check_eq("hs_timeout", 32'(0), 32'(1));
    endtask

    // Start pulse with a simultaneous valid byte that must not be taken
    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        check_eq("rdy_at_start", 32'(in_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'(1));
        check_eq("hold_after_start", 32'(cpu_hold), 32'(1));
        check_eq("done_cleared", 32'(done), 32'(0));
        check_eq("err_cleared", 32'(err), 32'(0));
    endtask

    // Send a full frame and check writes and outcome against the frame rule
    task automatic run_frame(input bit [7:0] pl[$], input bit [7:0] c,
                             input int gmin, input int gmax, input bit mid_start);
        int  len;
        int  base;
        int  s;
        bit  ok;
        bit  good;
        len  = pl.size();
        base = wr_total;
        s    = 0;
        send_byte(len[7:0], gmin, gmax, 1'b0, ok);
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i], gmin, gmax, mid_start && (i == 1), ok);
            check_eq("wr_en", 32'(wr_en), 32'(1));
            check_eq("wr_addr", 32'(wr_addr), 32'(i));
            check_eq("wr_data", 32'(wr_data), 32'(pl[i]));
            mem_exp[i] = pl[i];
            s = s + int'(pl[i]);
        end
        send_byte(c, gmin, gmax, 1'b0, ok);
        good = (((s + int'(c)) % 256) == 0);
        check_eq("done", 32'(done), 32'(good));
        check_eq("err", 32'(err), 32'(!good));
        check_eq("cpu_hold", 32'(cpu_hold), 32'(!good));
        check_eq("busy_end", 32'(busy), 32'(0));
        check_eq("rdy_end", 32'(in_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check_eq("wr_count", 32'(wr_total - base), 32'(len));
        check_eq("done_stable", 32'(done), 32'(good));
    endtask

    function automatic bit [7:0] good_csum(input bit [7:0] pl[$]);
        int s;
        s = 0;
        foreach (pl[i]) s = s + int'(pl[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    initial begin
        bit [7:0] q[$];
        bit       ok;
        int       base;
        int       diffs;

        n_cmp    = 0;
        n_mis    = 0;
        wr_total = 0;
        for (int i = 0; i < 256; i++) begin
            mem_obs[i] = 8'h00;
            mem_exp[i] = 8'h00;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'(0));
        check_eq("rst_wr_en", 32'(wr_en), 32'(0));
        check_eq("rst_wr_addr", 32'(wr_addr), 32'(0));
        check_eq("rst_wr_data", 32'(wr_data), 32'(0));
        check_eq("rst_cpu_hold", 32'(cpu_hold), 32'(1));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_err", 32'(err), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with noise on the stream: nothing may be accepted or written
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            check_eq("idle_hold", 32'(cpu_hold), 32'(1));
            check_eq("idle_rdy", 32'(in_ready), 32'(0));
            check_eq("idle_wr", 32'(wr_en), 32'(0));
            check_eq("idle_done", 32'(done), 32'(0));
            check_eq("idle_err", 32'(err), 32'(0));
        end
        in_valid = 1'b0;

        // Three-byte frame with a good checksum, back-to-back valid
        q = '{8'hA1, 8'hB2, 8'hC3};
        do_start();
        run_frame(q, good_csum(q), 0, 0, 1'b0);
        // Same payload with a C9 checksum byte: sum wraps to DF, so it fails
        do_start();
        run_frame(q, 8'hC9, 0, 0, 1'b0);
        // Same payload with a 00 checksum: fails, CPU stays held
        do_start();
        run_frame(q, 8'h00, 0, 0, 1'b0);
        // Recovery from ERR with a good frame
        do_start();
        run_frame(q, good_csum(q), 0, 0, 1'b0);

        // Empty frame
        q = {};
        do_start();
        run_frame(q, 8'h00, 0, 0, 1'b0);

        // Two-byte frame, valid every other cycle, start pulsed mid-frame
        q = '{8'h11, 8'h22};
        do_start();
        run_frame(q, good_csum(q), 1, 1, 1'b1);

        // Reset in the middle of a five-byte frame after two payload bytes
        do_start();
        base = wr_total;
        send_byte(8'd5, 0, 1, 1'b0, ok);
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h40 + 8'(i), 0, 1, 1'b0, ok);
            mem_exp[i] = 8'h40 + 8'(i);
        end
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_en", 32'(wr_en), 32'(0));
        check_eq("mid_rst_rdy", 32'(in_ready), 32'(0));
        check_eq("mid_rst_busy", 32'(busy), 32'(0));
        check_eq("mid_rst_hold", 32'(cpu_hold), 32'(1));
        check_eq("mid_rst_addr", 32'(wr_addr), 32'(0));
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_eq("mid_rst_writes", 32'(wr_total - base), 32'(2));
        check_eq("mid_rst_idle_rdy", 32'(in_ready), 32'(0));
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_start();
        run_frame(q, good_csum(q), 0, 1, 1'b0);

        // Randomized frames: random lengths, gaps and good/bad checksums
        for (int f = 0; f < 14; f++) begin
            int len;
            bit [7:0] c;
            len = (f == 7) ? 255 : int'($urandom_range(16, 0));
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            c = good_csum(q);
            if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
            do_start();
            run_frame(q, c, 0, (f == 7) ? 0 : 2, 1'($urandom));
        end

        // Whole observed memory image versus the model image
        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_obs[i] !== mem_exp[i]) diffs = diffs + 1;
        end
        check_eq("mem_image", 32'(diffs), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
